// File: rtl/mux_pipe_n.sv
// N-input selecting pipeline stage with a two-entry elastic buffer.
// Head beat lives in registers that drive Out/SelOut directly; a second entry absorbs one stall.
module mux_pipe_n #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [N*WIDTH-1:0]     In,
  input  logic [SEL_W-1:0]       S,
  input  logic                   InValid,
  output logic                   InReady,
  output logic [WIDTH-1:0]       Out,
  output logic [SEL_W-1:0]       SelOut,
  output logic                   OutValid,
  input  logic                   OutReady,
  input  logic                   Flush,
  output logic [1:0]             Count
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  occ_e                r_state;
  occ_e                w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_head_data;
  logic [SEL_W-1:0]    r_head_sel;
  logic [WIDTH-1:0]    r_tail_data;
  logic [SEL_W-1:0]    r_tail_sel;

  logic [SEL_W-1:0]    w_sel;
  logic [WIDTH-1:0]    w_data;
  logic                w_push;
  logic                w_pop;
  logic                w_load_head_in;
  logic                w_load_head_tail;
  logic                w_load_tail;

  // Out-of-range selects fall back to the last channel.
  always_comb begin
    w_sel = S;
    if ({1'b0, S} >= (SEL_W + 1)'(N)) begin
      w_sel = SEL_MAX;
    end
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (w_sel == SEL_W'(k)) begin
        w_data = In[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_push = InValid && r_in_ready;
  assign w_pop  = r_out_valid && OutReady;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy tracking; flush overrides any same-cycle push or pop.
  always_comb begin
    w_state_nxt = r_state;
    if (Flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt = ST_FULL;
          end else if (!w_push && w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Datapath load enables derived from occupancy and the handshakes.
  always_comb begin
    w_load_head_in   = 1'b0;
    w_load_head_tail = 1'b0;
    w_load_tail      = 1'b0;
    if (!Flush) begin
      case (r_state)
        ST_EMPTY: w_load_head_in = w_push;
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_load_head_in = 1'b1;
          end else if (w_push) begin
            w_load_tail = 1'b1;
          end
        end
        ST_FULL:  w_load_head_tail = w_pop;
        default: begin
          w_load_head_in   = 1'b0;
          w_load_head_tail = 1'b0;
          w_load_tail      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_head_data <= '0;
      r_head_sel  <= '0;
      r_tail_data <= '0;
      r_tail_sel  <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head_data <= w_data;
        r_head_sel  <= w_sel;
      end else if (w_load_head_tail) begin
        r_head_data <= r_tail_data;
        r_head_sel  <= r_tail_sel;
      end
      if (w_load_tail) begin
        r_tail_data <= w_data;
        r_tail_sel  <= w_sel;
      end
    end
  end

  // Handshake flags are registered from next occupancy so no ready/valid path is combinational.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  assign InReady  = r_in_ready;
  assign OutValid = r_out_valid;
  assign Out      = r_head_data;
  assign SelOut   = r_head_sel;
  assign Count    = r_state;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: directed steps plus random traffic against a queue-based reference.
// A second N=3 instance covers the out-of-range select fallback.
module tb_mux_pipe_n;

  localparam int unsigned W = 64;

  logic           CLK;
  logic           RESET_N;
  logic [4*W-1:0] In;
  logic [1:0]     S;
  logic           InValid;
  logic           InReady;
  logic [W-1:0]   Out;
  logic [1:0]     SelOut;
  logic           OutValid;
  logic           OutReady;
  logic           Flush;
  logic [1:0]     Count;

  logic [3*W-1:0] In3;
  logic [1:0]     S3;
  logic           InValid3;
  logic           InReady3;
  logic [W-1:0]   Out3;
  logic [1:0]     SelOut3;
  logic           OutValid3;
  logic           OutReady3;
  logic           Flush3;
  logic [1:0]     Count3;

  mux_pipe_n #(.WIDTH(W), .N(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .In(In), .S(S), .InValid(InValid), .InReady(InReady),
    .Out(Out), .SelOut(SelOut), .OutValid(OutValid), .OutReady(OutReady), .Flush(Flush),
    .Count(Count)
  );

  mux_pipe_n #(.WIDTH(W), .N(3)) dut3 (
    .CLK(CLK), .RESET_N(RESET_N), .In(In3), .S(S3), .InValid(InValid3), .InReady(InReady3),
    .Out(Out3), .SelOut(SelOut3), .OutValid(OutValid3), .OutReady(OutReady3), .Flush(Flush3),
    .Count(Count3)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
  } beat_t;

  logic [W-1:0] chan [4];
  beat_t        m_q [$];
  bit           m_in_ready;
  int           n_checks;
  int           n_errors;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_in();
    In = {chan[3], chan[2], chan[1], chan[0]};
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},     W'(Count),    W'(m_q.size()));
    chk({tag, ".out_valid"}, W'(OutValid), W'(m_q.size() != 0));
    chk({tag, ".in_ready"},  W'(InReady),  W'(m_in_ready));
    if (m_q.size() != 0) begin
      chk({tag, ".out"},     Out,          m_q[0].d);
      chk({tag, ".sel_out"}, W'(SelOut),   W'(m_q[0].s));
    end
  endtask

  // One clock edge: reference decides push/pop from the inputs held across the edge.
  task automatic cycle(input string tag);
    bit           push;
    bit           pop;
    bit           fl;
    int           si;
    beat_t        b;
    pack_in();
    push = RESET_N && InValid && m_in_ready;
    pop  = RESET_N && (m_q.size() != 0) && OutReady;
    fl   = Flush;
    si   = int'(S);
    if (si >= 4) si = 3;
    b.d  = chan[si];
    b.s  = 2'(si);
    @(posedge CLK);
    #1;
    if (!RESET_N) begin
      m_q.delete();
      m_in_ready = 1'b0;
    end else if (fl) begin
      m_q.delete();
      m_in_ready = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(b);
      m_in_ready = (m_q.size() != 2);
    end
    check_state(tag);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input bit ordy, input bit fl);
    InValid  = v;
    S        = s;
    OutReady = ordy;
    Flush    = fl;
  endtask

  task automatic new_chans();
    for (int i = 0; i < 4; i++) chan[i] = {$urandom, $urandom};
  endtask

  initial begin
    CLK = 0; RESET_N = 0; n_checks = 0; n_errors = 0; m_in_ready = 0;
    for (int i = 0; i < 4; i++) chan[i] = '0;
    drive(0, 0, 0, 0);
    In3 = '0; S3 = 0; InValid3 = 0; OutReady3 = 1; Flush3 = 0;
    pack_in();

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      cycle("reset_low");
      chk("reset_low.out", Out, '0);
      chk("reset_low.sel_out", W'(SelOut), '0);
    end
    RESET_N = 1;
    cycle("reset_release");

    // Select coverage with OutReady high
    chan[0] = {16{4'h1}}; chan[1] = {16{4'h2}}; chan[2] = {16{4'h3}}; chan[3] = {16{4'h4}};
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'(k), 1, 0);
      cycle("select");
      chk("select.out_const", Out, {16{4'(k + 1)}});
    end
    drive(0, 0, 1, 0);
    cycle("select_drain");

    // Out-of-range select on the N=3 instance
    In3 = {{16{4'hc}}, {16{4'hb}}, {16{4'ha}}};
    S3 = 3; InValid3 = 1;
    cycle("n3_step");
    chk("n3.sel_clamp", W'(SelOut3), W'(2));
    chk("n3.out_clamp", Out3, {16{4'hc}});
    S3 = 1;
    cycle("n3_step");
    chk("n3.sel_in_range", W'(SelOut3), W'(1));
    chk("n3.out_in_range", Out3, {16{4'hb}});
    InValid3 = 0;

    // Back-pressure: A, B accepted, C held, then drained in order
    new_chans(); drive(1, 0, 0, 0);
    cycle("bp_a");
    new_chans(); drive(1, 1, 0, 0);
    cycle("bp_b");
    new_chans(); drive(1, 2, 0, 0);
    for (int i = 0; i < 3; i++) cycle("bp_stall");
    drive(1, 2, 1, 0);
    cycle("bp_pop_a");
    cycle("bp_push_c");
    drive(0, 0, 1, 0);
    cycle("bp_pop_c");
    cycle("bp_idle");

    // Simultaneous push/pop at Count 1
    new_chans(); drive(1, 3, 0, 0);
    cycle("pp_a");
    new_chans(); drive(1, 1, 1, 0);
    cycle("pp_swap");
    drive(0, 0, 0, 0);
    cycle("pp_hold");

    // Flush at Count 2 with beat D offered
    drive(0, 0, 1, 0);
    cycle("fl_drain");
    new_chans(); drive(1, 0, 0, 0);
    cycle("fl_a");
    cycle("fl_b");
    drive(1, 2, 1, 1);
    cycle("fl_flush");
    drive(0, 0, 1, 0);
    cycle("fl_after");
    cycle("fl_after2");

    // Asynchronous reset mid-operation at Count 2
    new_chans(); drive(1, 1, 0, 0);
    cycle("rst_a");
    cycle("rst_b");
    #2 RESET_N = 0;
    #1;
    m_q.delete();
    m_in_ready = 1'b0;
    check_state("rst_async");
    chk("rst_async.out", Out, '0);
    chk("rst_async.sel_out", W'(SelOut), '0);
    #1 RESET_N = 1;
    drive(0, 0, 1, 0);
    cycle("rst_release");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      new_chans();
      drive(($urandom_range(0, 9) < 7), 2'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
